// File: rtl/if_icache_stage.sv
// Instruction-fetch stage with a direct-mapped, multi-word-line instruction cache.
// Misses refill the whole line from external memory over a req/ack handshake.
module if_icache_stage #(
  parameter int unsigned LINES          = 8,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC,
  input  logic        stall_in,
  input  logic        flush,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_instr,
  output logic        IF_valid,
  output logic        stall_out,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int unsigned OFS_W = $clog2(WORDS_PER_LINE);
  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = 30 - OFS_W - IDX_W;
  // Keep the word counter at least one bit wide for single-word lines.
  localparam int unsigned CNT_W = (OFS_W == 0) ? 1 : OFS_W;

  typedef enum logic [0:0] {StIdle, StRefill} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        base_q, base_d;
  logic [IDX_W-1:0]   ridx_q, ridx_d;
  logic [TAG_W-1:0]   rtag_q, rtag_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic [31:0]        if_pc_q, if_pc_d;
  logic [31:0]        if_instr_q, if_instr_d;
  logic               if_valid_q, if_valid_d;
  logic [31:0]        hit_cnt_q, hit_cnt_d;
  logic [31:0]        miss_cnt_q, miss_cnt_d;

  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [31:0]        data_q [LINES][WORDS_PER_LINE];

  logic [CNT_W-1:0]   pc_ofs;
  logic [IDX_W-1:0]   pc_idx;
  logic [TAG_W-1:0]   pc_tag;
  logic               lookup, hit, miss;
  logic               refill_ack, last_word, line_done;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign pc_ofs = CNT_W'((PC >> 2) & 32'(WORDS_PER_LINE - 1));
  assign pc_idx = IDX_W'(PC >> (OFS_W + 2));
  assign pc_tag = TAG_W'(PC >> (OFS_W + IDX_W + 2));

  // Lookup is suppressed while reset is asserted so stall_out drops with it.
  assign lookup = (state_q == StIdle) && reset && !stall_in && !flush;
  assign hit    = lookup && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
  assign miss   = lookup && !hit;

  assign refill_ack = (state_q == StRefill) && !flush && mem_ack;
  assign last_word  = (cnt_q == CNT_W'(WORDS_PER_LINE - 1));
  assign line_done  = refill_ack && last_word;

  assign stall_out = miss || (state_q == StRefill);
  assign mem_req   = (state_q == StRefill);
  assign mem_addr  = base_q | (32'(cnt_q) << 2);

  assign IF_PC    = if_pc_q;
  assign IF_instr = if_instr_q;
  assign IF_valid = if_valid_q;
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    base_d     = base_q;
    ridx_d     = ridx_q;
    rtag_d     = rtag_q;
    valid_d    = valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_valid_d = if_valid_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;

    if (flush) begin
      valid_d    = '0;
      if_valid_d = 1'b0;
      state_d    = StIdle;
      cnt_d      = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (hit) begin
            if_instr_d = data_q[pc_idx][pc_ofs];
            if_pc_d    = PC;
            if_valid_d = 1'b1;
            hit_cnt_d  = sat_inc(hit_cnt_q);
          end else if (miss) begin
            if_valid_d = 1'b0;
            miss_cnt_d = sat_inc(miss_cnt_q);
            base_d     = PC & ~32'(WORDS_PER_LINE * 4 - 1);
            ridx_d     = pc_idx;
            rtag_d     = pc_tag;
            cnt_d      = '0;
            state_d    = StRefill;
          end
        end
        StRefill: begin
          if_valid_d = 1'b0;
          if (mem_ack) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (last_word) begin
              valid_d[ridx_q] = 1'b1;
              cnt_d           = '0;
              state_d         = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      base_q     <= '0;
      ridx_q     <= '0;
      rtag_q     <= '0;
      valid_q    <= '0;
      if_pc_q    <= '0;
      if_instr_q <= '0;
      if_valid_q <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      base_q     <= base_d;
      ridx_q     <= ridx_d;
      rtag_q     <= rtag_d;
      valid_q    <= valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Line storage needs no reset: entries are only read once their valid bit is set.
  always_ff @(posedge clk) begin
    if (refill_ack) begin
      data_q[ridx_q][cnt_q] <= mem_rdata;
    end
    if (line_done) begin
      tag_q[ridx_q] <= rtag_q;
    end
  end

endmodule

// File: tb/tb_if_icache_stage.sv
// Scoreboard bench for if_icache_stage: expected fetches and refill addresses are queued
// by the stimulus and popped by a negedge monitor.
module tb_if_icache_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC;
  logic        stall_in;
  logic        flush;
  logic [31:0] IF_PC;
  logic [31:0] IF_instr;
  logic        IF_valid;
  logic        stall_out;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int errors = 0;
  int checks = 0;
  int ack_every = 1;
  int wait_cnt = 0;

  logic [31:0] exp_addr_q [$];
  logic [63:0] exp_fetch_q [$];

  if_icache_stage #(
    .LINES          (8),
    .WORDS_PER_LINE (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .PC        (PC),
    .stall_in  (stall_in),
    .flush     (flush),
    .IF_PC     (IF_PC),
    .IF_instr  (IF_instr),
    .IF_valid  (IF_valid),
    .stall_out (stall_out),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  always #5 clk = ~clk;

  // Memory model: data is address-derived; ack after (ack_every-1) wait cycles.
  assign mem_rdata = 32'h1000_0000 + mem_addr;
  always_comb mem_ack = mem_req && !flush && (wait_cnt == ack_every - 1);
  always @(posedge clk) begin
    if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor
  logic [31:0] prev_hit  = '0;
  logic        prev_req  = 1'b0;
  logic        prev_ack  = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [63:0] mon_e;

  always @(negedge clk) begin
    if (mem_req && prev_req && !prev_ack) check("mem_addr_stable", mem_addr, prev_addr);
    if (mem_req && mem_ack) begin
      if (exp_addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_refill: got addr %h expected no request", mem_addr);
      end else begin
        mon_e[31:0] = exp_addr_q.pop_front();
        check("mem_addr", mem_addr, mon_e[31:0]);
      end
    end
    if (hit_cnt == prev_hit + 32'd1) begin
      if (exp_fetch_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_fetch: got pc %h expected no fetch", IF_PC);
      end else begin
        mon_e = exp_fetch_q.pop_front();
        check("fetch_pc", IF_PC, mon_e[63:32]);
        check("fetch_instr", IF_instr, mon_e[31:0]);
        check("fetch_valid", 32'(IF_valid), 32'd1);
      end
    end
    prev_hit  = hit_cnt;
    prev_req  = mem_req;
    prev_ack  = mem_ack;
    prev_addr = mem_addr;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_line(input logic [31:0] base);
    for (int i = 0; i < 4; i++) exp_addr_q.push_back(base + 32'(i * 4));
  endtask

  // Present pc until it hits; counts cycles with stall_out high.
  task automatic fetch(input logic [31:0] pc, input int exp_stalls, input string name);
    int stalls = 0;
    bit done = 1'b0;
    exp_fetch_q.push_back({pc, 32'h1000_0000 + pc});
    PC = pc;
    stall_in = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      #1;
      if (!stall_out) done = 1'b1;
      else stalls++;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no hit expected hit within 100 cycles", name);
    end
    stall_in = 1'b1;
    check(name, 32'(stalls), 32'(exp_stalls));
  endtask

  initial begin
    reset    = 1'b0;
    PC       = '0;
    stall_in = 1'b1;
    flush    = 1'b0;
    repeat (3) tick();
    check("rst_IF_PC", IF_PC, 32'h0);
    check("rst_IF_instr", IF_instr, 32'h0);
    check("rst_IF_valid", 32'(IF_valid), 32'd0);
    check("rst_hit_cnt", hit_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_stall_out", 32'(stall_out), 32'd0);
    reset = 1'b1;
    tick();

    // Cold miss then hits in the same line
    push_line(32'h00);
    fetch(32'h00, 5, "cold_stalls");
    fetch(32'h04, 0, "hit04_stalls");
    fetch(32'h08, 0, "hit08_stalls");
    fetch(32'h0C, 0, "hit0C_stalls");
    check("cold_hit_cnt", hit_cnt, 32'd4);
    check("cold_miss_cnt", miss_cnt, 32'd1);

    // Conflict on index 0
    push_line(32'h80);
    fetch(32'h80, 5, "conflict80_stalls");
    push_line(32'h00);
    fetch(32'h00, 5, "conflict00_stalls");
    check("conflict_miss_cnt", miss_cnt, 32'd3);
    check("conflict_hit_cnt", hit_cnt, 32'd6);

    // Two wait states per word
    ack_every = 3;
    push_line(32'h40);
    fetch(32'h40, 13, "wait_stalls");
    ack_every = 1;
    check("wait_miss_cnt", miss_cnt, 32'd4);

    // Downstream stall holds outputs
    fetch(32'h04, 0, "pre_stall_hit");
    PC = 32'h08;
    repeat (3) begin
      tick();
      check("hold_IF_PC", IF_PC, 32'h04);
      check("hold_IF_instr", IF_instr, 32'h1000_0004);
      check("hold_IF_valid", 32'(IF_valid), 32'd1);
      check("hold_hit_cnt", hit_cnt, 32'd8);
    end
    fetch(32'h08, 0, "post_stall_hit");

    // Flush after two acks of a refill at 0x20
    stall_in = 1'b0;
    PC = 32'h20;
    exp_addr_q.push_back(32'h20);
    exp_addr_q.push_back(32'h24);
    #1;
    check("flush_miss_stall", 32'(stall_out), 32'd1);
    tick();
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_mem_req", 32'(mem_req), 32'd0);
    check("flush_miss_cnt", miss_cnt, 32'd5);
    push_line(32'h20);
    fetch(32'h20, 5, "reflush20_stalls");
    push_line(32'h00);
    fetch(32'h00, 5, "flushed00_stalls");
    check("flush_final_miss", miss_cnt, 32'd7);
    check("flush_final_hit", hit_cnt, 32'd11);

    // Asynchronous reset during a refill
    stall_in = 1'b0;
    PC = 32'h40;
    tick();
    check("prerst_mem_req", 32'(mem_req), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_mem_req", 32'(mem_req), 32'd0);
    check("arst_IF_valid", 32'(IF_valid), 32'd0);
    check("arst_hit_cnt", hit_cnt, 32'd0);
    check("arst_miss_cnt", miss_cnt, 32'd0);
    check("arst_stall_out", 32'(stall_out), 32'd0);
    tick();
    stall_in = 1'b1;
    reset = 1'b1;
    tick();
    push_line(32'h00);
    fetch(32'h00, 5, "after_rst_stalls");
    check("after_rst_miss", miss_cnt, 32'd1);
    check("after_rst_hit", hit_cnt, 32'd1);

    tick();
    tick();
    check("addr_q_drained", 32'(exp_addr_q.size()), 32'd0);
    check("fetch_q_drained", 32'(exp_fetch_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_icache_stage.md
# if_icache_stage

Parametrised instruction-fetch stage with a direct-mapped, multi-word-line instruction cache. On a miss it refills the line from an external instruction memory through a req/ack handshake. It sits between the PC register and the IF/ID pipeline register. Compared with the single-word, internal-memory fetch stage, it adds:
- configurable line count and line width,
- multi-cycle refill with wait-state tolerance,
- downstream stall and flush,
- hit/miss performance counters.

## Interface
Parameters:
- LINES, 8: number of cache lines; power of two, ≥2
- WORDS_PER_LINE, 4: 32-bit words per line; power of two, ≥1
- Derived: OFS_W = log2(WORDS_PER_LINE), IDX_W = log2(LINES), TAG_W = 30 − OFS_W − IDX_W

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- PC  in  32  fetch address; PC[1:0] ignored
- stall_in  in  1  downstream hold; freezes IF outputs
- flush  in  1  invalidate all lines and abort any refill
- IF_PC  out  32  PC of the instruction in IF_instr
- IF_instr  out  32  fetched instruction
- IF_valid  out  1  IF_instr/IF_PC are a real fetch (0 = bubble)
- stall_out  out  1  PC must be held this cycle (combinational)
- mem_req  out  1  refill word request
- mem_addr  out  32  word address of the request; bits [1:0] = 0
- mem_ack  in  1  memory accepts the request and mem_rdata is valid this cycle
- mem_rdata  in  32  refill data
- hit_cnt  out  32  saturating count of lookup hits
- miss_cnt  out  32  saturating count of lookup misses

## Operation
- Address split: offset = PC[OFS_W+1:2], idx = PC[OFS_W+IDX_W+1:OFS_W+2], tag = PC[31:OFS_W+IDX_W+2].
- Storage per line:
  - valid bit
  - TAG_W tag
  - WORDS_PER_LINE × 32 data
- FSM states: IDLE, REFILL.
- IDLE, lookup every cycle in which stall_in = 0 and flush = 0:
  - Hit (valid[idx] and tag match): IF_instr ← data[idx][offset], IF_PC ← PC, IF_valid ← 1, hit_cnt++.
  - Miss: IF_valid ← 0, miss_cnt++, refill base ← {PC[31:OFS_W+2], 0…}, word counter ← 0, go to REFILL.
- stall_out = miss in IDLE, or state == REFILL. stall_in does not drive stall_out; upstream combines the two.
- REFILL:
  - mem_req = 1; mem_addr = base + 4·counter.
  - On each edge with mem_ack = 1: data[idx][counter] ← mem_rdata, counter++.
  - On the ack for the last word: tag[idx] ← tag, valid[idx] ← 1, go to IDLE.
  - IF_valid = 0 throughout; IF_PC and IF_instr hold.
- The returning IDLE cycle re-looks-up the held PC; that lookup hits and is counted as a hit.
- mem_addr and mem_req stay stable while mem_req = 1 and mem_ack = 0. mem_req = 0 in IDLE. Memory must not retain a request after mem_req drops.
- stall_in = 1 in IDLE: IF_PC, IF_instr and IF_valid hold; no lookup; counters unchanged. A refill in progress continues regardless of stall_in.
- flush (priority over everything except reset):
  - All valid bits cleared; IF_valid ← 0; counters unchanged.
  - In REFILL: abort, go to IDLE; the partial line stays invalid.
- Counters saturate at 0xFFFF_FFFF.

## Timing
- Reset (asynchronous, active-low) forces immediately, including mid-refill:
  - IF_PC = 0, IF_instr = 0, IF_valid = 0
  - hit_cnt = 0, miss_cnt = 0
  - mem_req = 0, all valid bits = 0, state = IDLE, counter = 0
- stall_out = 0 out of reset until the first miss.
- Hit latency: 1 cycle (PC presented at cycle n → IF outputs valid after edge n).
- Miss penalty with zero-wait memory (mem_ack tied 1): 1 detect cycle + WORDS_PER_LINE refill cycles, then the hit cycle. stall_out is high for 1 + WORDS_PER_LINE cycles.
- Each wait state (mem_ack = 0 while mem_req = 1) adds one cycle.
- flush during REFILL: mem_req = 0 from the following cycle.

## Test plan
Bench memory model returns mem_rdata = 0x1000_0000 + mem_addr. Parameters are defaults unless stated.
- Cold miss:
  - Stimulus: release reset, PC = 0x00, mem_ack = 1.
  - stall_out is high 5 cycles; mem_addr steps 0x00, 0x04, 0x08, 0x0C.
  - IF_instr = 0x1000_0000, IF_valid = 1.
  - Then PC = 0x04, 0x08, 0x0C hit with stall_out = 0; final hit_cnt = 4, miss_cnt = 1.
- Conflict: PC 0x00 → 0x80 (same idx 0) → 0x00 gives three misses, miss_cnt = 3, and IF_instr = 0x1000_0080 then 0x1000_0000.
- Wait states:
  - Stimulus: mem_ack high only every 3rd cycle during a refill at PC = 0x40.
  - mem_addr is held stable between acks; the refill takes 12 cycles.
  - The line becomes valid only after the 4th ack.
- stall_in:
  - Stimulus: after a hit at 0x04, hold stall_in = 1 for 3 cycles while PC = 0x08.
  - IF_PC = 0x04 and IF_instr = 0x1000_0004 stay stable; hit_cnt is unchanged.
- Flush mid-refill:
  - Stimulus: pulse flush after 2 acks of a refill at 0x20.
  - mem_req = 0 the next cycle; re-lookup of 0x20 misses; the refill restarts at mem_addr 0x20.
  - A previously cached 0x00 also misses.
- Reset mid-refill:
  - Stimulus: assert reset between clock edges during a refill.
  - mem_req, IF_valid, the counters and stall_out drop to 0 without waiting for a clock edge.
  - After release, PC = 0x00 misses again.
